stamp_board: RTL and testbench
==============================

Name: stamp_board

Overview:
- Issue-side counterpart of the execution units. Holds up to SLOTS in-flight instruction records and publishes them as reg_out_flat / reg_start_flat.
- Absorbs stamp and take write-backs from the units, gates writeback in program order, and retires completed records one per cycle.
- Sits between decode/dispatch and the mov/alu units.
- Slot SLOTS-1 always holds the oldest record. Units scan from the top index down, so the oldest instruction wins.

Parameters:
- SLOTS, 8, number of record slots; flat port widths scale with it.
- INSTR_W, 88, record width: [87:82] opcode, [81:77] rs, [71:67] rd, [66:35] imm, [34:30] take index, [2:0] stamp.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- disp_valid  in  1  dispatch request
- disp_instr  in  INSTR_W  record to enqueue; bits [34:30] and [2:0] are ignored
- disp_ready  out  1  a slot is free
- reg_start_flat  out  SLOTS*3  per-slot grant: 100 = may execute, 001 = may write back, 000 = idle
- reg_out_flat  out  SLOTS*INSTR_W  slot records; slot i occupies [INSTR_W*i +: INSTR_W]
- stamp_flat  in  SLOTS*3  new stamp per slot
- stamp_in  in  SLOTS  per-slot stamp write enable
- take_flat  in  SLOTS*5  data-buffer index per slot
- take_in  in  SLOTS  per-slot take write enable
- retire_valid  out  1  one-cycle pulse when a record retires
- retire_instr  out  INSTR_W  the retired record
- count  out  4  occupied slots (clog2(SLOTS)+1 bits)

Behaviour:
- **Storage:** compacted queue. Valid slots are always SLOTS-1 down to SLOTS-count. Empty slots read as all-zero records with stamp 000.
- **Slot grants** (reg_start), combinational from registered state only (no input-to-output paths):
  - 100 when the slot is valid and stamp == 000.
  - 001 when the slot is valid, stamp[2]=1, stamp[0]=0, and every valid higher-index slot has stamp[0]=1. This enforces in-order writeback.
  - 000 otherwise, including all empty slots.
- **Stamp writes:** on stamp_in[i] for a valid slot, stamp <= stamp_flat[3i+:3]. The whole 3-bit field is replaced; stamp[1] is stored unchanged. stamp_in on an empty slot is ignored.
- **Take writes:** on take_in[i] for a valid slot, record[34:30] <= take_flat[5i+:5]. take_in on an empty slot is ignored.
- **Retire condition:** slot SLOTS-1 is valid with stamp[2]=1 and stamp[0]=1.
- **On a retire cycle:**
  - retire_valid=1 and retire_instr = the slot SLOTS-1 record as held at the start of the cycle.
  - Every slot shifts up by one.
  - Any stamp/take write addressed to slot i lands in slot i+1.
  - Any write addressed to slot SLOTS-1 is dropped.
- **Dispatch:**
  - disp_ready = (count < SLOTS), taken from registered count; a retire in the same cycle does not raise it.
  - On disp_valid && disp_ready, the record enters slot SLOTS-1-count, or SLOTS-count when retiring in the same cycle.
  - On entry, stamp <= 000 and [34:30] <= 0.
  - disp_valid while not ready is ignored; no hold is required of the board.
- **count update:** +1 on dispatch, -1 on retire, unchanged when both occur in the same cycle.
- **Visibility:** all updates appear on outputs the cycle after the write. The retire pulse lasts one cycle.
- **Reset:** on rst_n=0 at clk:
  - All slots become empty: records 0, stamps 000.
  - count=0, retire_valid=0, retire_instr=0, disp_ready=1 after the edge.
  - Reset mid-operation discards all in-flight records without retiring them.
  - Stamp/take/dispatch inputs in the reset cycle are ignored.

Optional Feature:
- **Macro:** STAMP_BOARD_FLUSH_EN.
- **When defined:**
  - Adds input flush (1 bit).
  - flush=1 at clk empties all slots and sets count=0, with the same effect as reset except retire_instr holds its value.
  - flush has priority over dispatch, stamp, take and retire in that cycle.
  - retire_valid=0 in that cycle.
- **When undefined:** no flush port; behaviour is exactly as above.

Test Plan:
- **Reset and single MOV:**
  - Stimulus: reset, then dispatch MOV (opcode 101010).
  - Required: next cycle, slot 7 reg_start=100 and count=1.
  - Then stamp_in[7] with 100 plus take_in[7] with 5'd3. Required: next cycle, reg_start[7]=001 and record[34:30]=3.
  - Then stamp_in[7] with 101. Required: next cycle, retire_valid=1, retire_instr[87:82]=101010, count=0.
- **In-order writeback:**
  - Stimulus: dispatch A then B. Stamp B with 100 first, then A with 100.
  - Required: B (slot 6) stays 000 while A's stamp[0]=0. B shows 001 only after A is stamped 101.
- **Full:**
  - Stimulus: dispatch 8 records.
  - Required: count=8, disp_ready=0. A 9th disp_valid is ignored and count stays 8.
- **Retire plus stamp in the same cycle:**
  - Stimulus: slot 7 is retirable and stamp_in[5] with 100 is applied in that cycle.
  - Required: the new stamp appears in slot 6 and the retired record is emitted.
- **Retire plus dispatch at full:**
  - Stimulus: board full, slot 7 retiring, disp_valid=1.
  - Required: dispatch ignored (disp_ready=0); count goes 8 -> 7.
- **Flush (STAMP_BOARD_FLUSH_EN):**
  - Stimulus: 5 records in flight, assert flush.
  - Required: next cycle count=0, all reg_start=000, retire_valid=0.

Source files
------------

// File: rtl/stamp_board.sv
// stamp_board: compacted board of in-flight instruction records with in-order writeback gating.
// Define STAMP_BOARD_FLUSH_EN to add a flush input that empties the board in one cycle.
module stamp_board #(
  parameter int SLOTS   = 8,
  parameter int INSTR_W = 88
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef STAMP_BOARD_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     disp_valid,
  input  logic [INSTR_W-1:0]       disp_instr,
  output logic                     disp_ready,
  output logic [SLOTS*3-1:0]       reg_start_flat,
  output logic [SLOTS*INSTR_W-1:0] reg_out_flat,
  input  logic [SLOTS*3-1:0]       stamp_flat,
  input  logic [SLOTS-1:0]         stamp_in,
  input  logic [SLOTS*5-1:0]       take_flat,
  input  logic [SLOTS-1:0]         take_in,
  output logic                     retire_valid,
  output logic [INSTR_W-1:0]       retire_instr,
  output logic [$clog2(SLOTS):0]   count
);
  localparam int CNT_W = $clog2(SLOTS) + 1;

  typedef logic [INSTR_W-1:0] rec_t;

  rec_t             rec_q [SLOTS];
  rec_t             rec_d [SLOTS];
  rec_t             upd   [SLOTS];
  rec_t             disp_rec;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] disp_slot;
  logic             retire_valid_q;
  rec_t             retire_instr_q, retire_instr_d;
  logic [SLOTS-1:0] slot_valid;
  logic             retire_now;
  logic             disp_fire;

  // Valid slots are packed against the top index, so validity follows from count alone.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign slot_valid[gi] = (CNT_W'(SLOTS - gi) <= count_q);
    assign reg_out_flat[INSTR_W*gi +: INSTR_W] = rec_q[gi];
  end

  assign disp_ready   = (count_q < CNT_W'(SLOTS));
  assign retire_valid = retire_valid_q;
  assign retire_instr = retire_instr_q;
  assign count        = count_q;

  always_comb begin : grant_logic
    logic clear_above;
    reg_start_flat = '0;
    clear_above    = 1'b1;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slot_valid[i]) begin
        if (rec_q[i][2:0] == 3'b000) begin
          reg_start_flat[3*i +: 3] = 3'b100;
        end else if (rec_q[i][2] && !rec_q[i][0] && clear_above) begin
          reg_start_flat[3*i +: 3] = 3'b001;
        end
        clear_above = clear_above & rec_q[i][0];
      end
    end
  end

  always_comb begin
    retire_now = slot_valid[SLOTS-1] && rec_q[SLOTS-1][2] && rec_q[SLOTS-1][0];
    disp_fire  = disp_valid && disp_ready;

    disp_rec        = disp_instr;
    disp_rec[34:30] = 5'd0;
    disp_rec[2:0]   = 3'd0;

    for (int i = 0; i < SLOTS; i++) begin
      upd[i] = rec_q[i];
      if (slot_valid[i] && stamp_in[i]) upd[i][2:0]   = stamp_flat[3*i +: 3];
      if (slot_valid[i] && take_in[i])  upd[i][34:30] = take_flat[5*i +: 5];
    end

    // A retire shifts everything up; writes ride along with their record.
    rec_d[0] = retire_now ? '0 : upd[0];
    for (int i = 1; i < SLOTS; i++) begin
      rec_d[i] = retire_now ? upd[i-1] : upd[i];
    end

    disp_slot = retire_now ? (CNT_W'(SLOTS) - count_q) : (CNT_W'(SLOTS - 1) - count_q);
    for (int i = 0; i < SLOTS; i++) begin
      if (disp_fire && disp_slot == CNT_W'(i)) rec_d[i] = disp_rec;
    end

    count_d = count_q;
    if (disp_fire && !retire_now) begin
      count_d = count_q + 1'b1;
    end else if (!disp_fire && retire_now) begin
      count_d = count_q - 1'b1;
    end

    retire_instr_d = retire_now ? rec_q[SLOTS-1] : retire_instr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) rec_q[i] <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_instr_q <= '0;
    end
`ifdef STAMP_BOARD_FLUSH_EN
    else if (flush) begin
      for (int i = 0; i < SLOTS; i++) rec_q[i] <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
    end
`endif
    else begin
      for (int i = 0; i < SLOTS; i++) rec_q[i] <= rec_d[i];
      count_q        <= count_d;
      retire_valid_q <= retire_now;
      retire_instr_q <= retire_instr_d;
    end
  end

endmodule

// File: tb/tb_stamp_board.sv
// Bench for stamp_board: queue-based program-order model checked every cycle, plus literal spot checks.
// Flush scenario is compiled in only when STAMP_BOARD_FLUSH_EN is defined.
module tb_stamp_board;
  localparam int SLOTS   = 8;
  localparam int INSTR_W = 88;
  localparam int FW      = SLOTS * INSTR_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
`ifdef STAMP_BOARD_FLUSH_EN
  logic                   flush;
`endif
  logic                   disp_valid;
  logic [INSTR_W-1:0]     disp_instr;
  logic                   disp_ready;
  logic [SLOTS*3-1:0]     reg_start_flat;
  logic [FW-1:0]          reg_out_flat;
  logic [SLOTS*3-1:0]     stamp_flat;
  logic [SLOTS-1:0]       stamp_in;
  logic [SLOTS*5-1:0]     take_flat;
  logic [SLOTS-1:0]       take_in;
  logic                   retire_valid;
  logic [INSTR_W-1:0]     retire_instr;
  logic [$clog2(SLOTS):0] count;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  stamp_board #(.SLOTS(SLOTS), .INSTR_W(INSTR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef STAMP_BOARD_FLUSH_EN
    .flush          (flush),
`endif
    .disp_valid     (disp_valid),
    .disp_instr     (disp_instr),
    .disp_ready     (disp_ready),
    .reg_start_flat (reg_start_flat),
    .reg_out_flat   (reg_out_flat),
    .stamp_flat     (stamp_flat),
    .stamp_in       (stamp_in),
    .take_flat      (take_flat),
    .take_in        (take_in),
    .retire_valid   (retire_valid),
    .retire_instr   (retire_instr),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Program-order model: mq[0] is the oldest record, living in slot SLOTS-1.
  logic [INSTR_W-1:0] mq[$];
  logic               exp_rv = 1'b0;
  logic [INSTR_W-1:0] exp_ri = '0;
  logic [INSTR_W-1:0] m_rec, m_old;
  int                 m_n;
  bit                 m_ret;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      exp_rv = 1'b0;
      exp_ri = '0;
    end
`ifdef STAMP_BOARD_FLUSH_EN
    else if (flush) begin
      mq.delete();
      exp_rv = 1'b0;
    end
`endif
    else begin
      m_n   = mq.size();
      m_ret = 1'b0;
      m_old = '0;
      if (m_n > 0) begin
        m_old = mq[0];
        m_ret = m_old[2] && m_old[0];
      end
      for (int s = 0; s < SLOTS; s++) begin
        if (SLOTS - 1 - s < m_n) begin
          m_rec = mq[SLOTS-1-s];
          if (stamp_in[s]) m_rec[2:0]   = stamp_flat[3*s +: 3];
          if (take_in[s])  m_rec[34:30] = take_flat[5*s +: 5];
          mq[SLOTS-1-s] = m_rec;
        end
      end
      if (m_ret) begin
        void'(mq.pop_front());
        exp_ri = m_old;
      end
      exp_rv = m_ret;
      if (disp_valid && m_n < SLOTS) begin
        m_rec        = disp_instr;
        m_rec[34:30] = 5'd0;
        m_rec[2:0]   = 3'd0;
        mq.push_back(m_rec);
      end
    end
  end

  logic [FW-1:0]          e_out;
  logic [SLOTS*3-1:0]     e_start;
  logic [INSTR_W-1:0]     c_rec;
  bit                     older_done;

  always @(negedge clk) begin
    if (check_en) begin
      e_out      = '0;
      e_start    = '0;
      older_done = 1'b1;
      for (int k = 0; k < mq.size(); k++) begin
        c_rec = mq[k];
        e_out[INSTR_W*(SLOTS-1-k) +: INSTR_W] = c_rec;
        if (c_rec[2:0] == 3'b000)
          e_start[3*(SLOTS-1-k) +: 3] = 3'b100;
        else if (c_rec[2] && !c_rec[0] && older_done)
          e_start[3*(SLOTS-1-k) +: 3] = 3'b001;
        older_done = older_done && c_rec[0];
      end
      chk("reg_out", reg_out_flat, e_out);
      chk("reg_start", reg_start_flat, e_start);
      chk("count", count, mq.size());
      chk("disp_ready", disp_ready, mq.size() < SLOTS);
      chk("retire_valid", retire_valid, exp_rv);
      chk("retire_instr", retire_instr, exp_ri);
    end
  end

  function automatic logic [INSTR_W-1:0] mk(input logic [5:0] op, input logic [31:0] imm);
    return {op, 5'd3, 5'h1F, 5'd9, imm, 5'h1B, 27'h5A5A5A5, 3'b111};
  endfunction

  function automatic logic [INSTR_W-1:0] slot_rec(input int s);
    return reg_out_flat[INSTR_W*s +: INSTR_W];
  endfunction

  function automatic logic [2:0] grant(input int s);
    return reg_start_flat[3*s +: 3];
  endfunction

  task automatic idle();
    disp_valid = 1'b0;
    stamp_in   = '0;
    take_in    = '0;
`ifdef STAMP_BOARD_FLUSH_EN
    flush      = 1'b0;
`endif
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic disp(input logic [5:0] op);
    disp_valid = 1'b1;
    disp_instr = mk(op, 32'hC0DE0000 | 32'(op));
  endtask

  task automatic set_stamp(input int s, input logic [2:0] v);
    stamp_in[s]         = 1'b1;
    stamp_flat[3*s +: 3] = v;
  endtask

  task automatic set_take(input int s, input logic [4:0] v);
    take_in[s]          = 1'b1;
    take_flat[5*s +: 5] = v;
  endtask

  logic [INSTR_W-1:0] tmp;

  initial begin
    rst_n      = 1'b0;
    disp_instr = '0;
    stamp_flat = '0;
    take_flat  = '0;
    idle();
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_rv", retire_valid, 0);
    chk("rst_ri", retire_instr, 0);
    chk("rst_start", reg_start_flat, 0);
    rst_n = 1'b1;

    // single MOV through its whole life
    disp(6'b101010); step();
    chk("mov_count", count, 1);
    chk("mov_grant_exec", grant(7), 3'b100);
    tmp = slot_rec(7);
    chk("mov_entry_stamp", tmp[2:0], 0);
    chk("mov_entry_take", tmp[34:30], 0);
    set_stamp(7, 3'b100); set_take(7, 5'd3); step();
    chk("mov_grant_wb", grant(7), 3'b001);
    tmp = slot_rec(7);
    chk("mov_take", tmp[34:30], 3);
    set_stamp(7, 3'b101); step();
    chk("mov_done_grant", grant(7), 3'b000);
    step();
    chk("mov_retire_v", retire_valid, 1);
    tmp = retire_instr;
    chk("mov_retire_op", tmp[87:82], 6'b101010);
    chk("mov_retire_cnt", count, 0);
    step();
    chk("mov_pulse_end", retire_valid, 0);

    // in-order writeback: B finishes before A
    disp(6'd1); step();
    disp(6'd2); step();
    set_stamp(6, 3'b100); step();
    chk("ord_b_blocked", grant(6), 3'b000);
    set_stamp(7, 3'b100); step();
    chk("ord_a_wb", grant(7), 3'b001);
    chk("ord_b_still", grant(6), 3'b000);
    set_stamp(7, 3'b101); step();
    chk("ord_b_released", grant(6), 3'b001);
    step();
    tmp = retire_instr;
    chk("ord_a_retired", tmp[87:82], 6'd1);
    chk("ord_b_top", grant(7), 3'b001);
    set_stamp(7, 3'b101); step(); step();
    chk("ord_empty", count, 0);

    // fill to capacity, then a rejected ninth dispatch
    for (int i = 0; i < SLOTS; i++) begin
      disp(6'(16 + i)); step();
    end
    chk("full_count", count, 8);
    chk("full_ready", disp_ready, 0);
    disp(6'd63); step();
    chk("full_ninth", count, 8);
    tmp = slot_rec(0);
    chk("full_slot0", tmp[87:82], 6'd23);

    // retire at full with a stamp/take to slot 5, dispatch, and a dropped write to slot 7
    set_stamp(7, 3'b101); step();
    set_stamp(5, 3'b100); set_take(5, 5'd9); set_stamp(7, 3'b000); disp(6'd62); step();
    chk("rs_retire_v", retire_valid, 1);
    tmp = retire_instr;
    chk("rs_retire_op", tmp[87:82], 6'd16);
    chk("rs_count", count, 7);
    tmp = slot_rec(6);
    chk("rs_slot6_op", tmp[87:82], 6'd18);
    chk("rs_slot6_stamp", tmp[2:0], 3'b100);
    chk("rs_slot6_take", tmp[34:30], 5'd9);
    chk("rs_slot0_empty", slot_rec(0), 0);

    // retire plus dispatch when not full; write to the empty slot 0 is ignored
    set_stamp(7, 3'b111); step();
    disp(6'd61); set_stamp(0, 3'b100); step();
    chk("rd_count", count, 7);
    tmp = slot_rec(1);
    chk("rd_slot1_op", tmp[87:82], 6'd61);
    chk("rd_slot0_empty", slot_rec(0), 0);

    // mixed traffic
    for (int c = 0; c < 200; c++) begin
      disp_valid = 1'($urandom_range(0, 1));
      disp_instr = {$urandom(), $urandom(), $urandom()};
      stamp_in   = 8'($urandom());
      stamp_flat = 24'($urandom());
      take_in    = 8'($urandom());
      take_flat  = 40'({$urandom(), $urandom()});
      @(negedge clk);
    end
    idle();

    // reset mid-operation discards everything
    disp(6'd5); step();
    rst_n = 1'b0; disp(6'd6); stamp_in = '1; stamp_flat = '1; step();
    rst_n = 1'b1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rv", retire_valid, 0);
    chk("mid_rst_ri", retire_instr, 0);
    chk("mid_rst_out", reg_out_flat, 0);

`ifdef STAMP_BOARD_FLUSH_EN
    for (int i = 0; i < 5; i++) begin
      disp(6'(40 + i)); step();
    end
    chk("fl_pre_count", count, 5);
    set_stamp(7, 3'b101); step();
    flush = 1'b1; disp(6'd50); set_stamp(6, 3'b100); step();
    chk("fl_count", count, 0);
    chk("fl_start", reg_start_flat, 0);
    chk("fl_rv", retire_valid, 0);
    chk("fl_ri_hold", retire_instr, 0);
`endif

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
